// File: rtl/psum_collector.sv
// psum_collector: drains one PE's partial-sum FIFO, accumulates num_ch words
// per 3x6 tile, requantizes each of the 18 sums to int8 and streams them out.
module psum_collector #(
    parameter int PSUM_WIDTH = 24,
    parameter int ACC_WIDTH  = PSUM_WIDTH + 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [CNT_WIDTH-1:0]     num_ch_i,
    input  logic [CNT_WIDTH-1:0]     num_tiles_i,
    input  logic [4:0]               shift_i,
    input  logic                     relu_en_i,
    input  logic [18*PSUM_WIDTH-1:0] fifo_dout_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_en_o,
    output logic [7:0]               act_o,
    output logic                     act_valid_o,
    input  logic                     act_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int N_ELEM = 18;

    // DONE is a one-cycle state so that a start coinciding with done_o is ignored.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUTPUT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-128);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   ch_cnt_q, ch_cnt_d;
    logic [CNT_WIDTH-1:0]   tile_cnt_q, tile_cnt_d;
    logic [4:0]             idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   num_ch_q, num_ch_d;
    logic [CNT_WIDTH-1:0]   num_tiles_q, num_tiles_d;
    logic [4:0]             shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic [ACC_WIDTH-1:0]   acc_q [N_ELEM];
    logic [ACC_WIDTH-1:0]   acc_d [N_ELEM];

    logic                   last_ch_s;
    logic                   last_tile_s;
    logic                   last_idx_s;
    logic                   accept_s;

    // Arithmetic shift (floor), optional ReLU, then saturate to int8.
    function automatic logic [7:0] requant(input logic [ACC_WIDTH-1:0] x,
                                           input logic [4:0]           sh,
                                           input logic                 relu);
        logic signed [ACC_WIDTH-1:0] y;
        logic [7:0]                  r;
        y = $signed(x) >>> sh;
        if (relu && y[ACC_WIDTH-1]) begin
            y = '0;
        end else begin
            y = y;
        end
        if (y > SAT_MAX) begin
            r = 8'h7f;
        end else if (y < SAT_MIN) begin
            r = 8'h80;
        end else begin
            r = y[7:0];
        end
        return r;
    endfunction

    assign last_ch_s   = (ch_cnt_q == (num_ch_q - CNT_WIDTH'(1)));
    assign last_tile_s = (tile_cnt_q == (num_tiles_q - CNT_WIDTH'(1)));
    assign last_idx_s  = (idx_q == 5'd17);
    assign accept_s    = (state_q == S_OUTPUT) && act_ready_i;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_cnt_q    <= '0;
            tile_cnt_q  <= '0;
            idx_q       <= 5'd0;
            num_ch_q    <= CNT_WIDTH'(1);
            num_tiles_q <= CNT_WIDTH'(1);
            shift_q     <= 5'd0;
            relu_q      <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            idx_q       <= idx_d;
            num_ch_q    <= num_ch_d;
            num_tiles_q <= num_tiles_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            for (int i = 0; i < N_ELEM; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
                else         state_d = S_IDLE;
            end
            S_FETCH: begin
                if (!fifo_empty_i) state_d = S_CAPTURE;
                else               state_d = S_FETCH;
            end
            S_CAPTURE: begin
                if (last_ch_s) state_d = S_OUTPUT;
                else           state_d = S_FETCH;
            end
            S_OUTPUT: begin
                if (accept_s && last_idx_s) begin
                    if (last_tile_s) state_d = S_DONE;
                    else             state_d = S_FETCH;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Config latch, counters and accumulator updates.
    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        idx_d       = idx_q;
        num_ch_d    = num_ch_q;
        num_tiles_d = num_tiles_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        for (int i = 0; i < N_ELEM; i++) begin
            acc_d[i] = acc_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_ch_d    = (num_ch_i == '0) ? CNT_WIDTH'(1) : num_ch_i;
                    num_tiles_d = (num_tiles_i == '0) ? CNT_WIDTH'(1) : num_tiles_i;
                    shift_d     = shift_i;
                    relu_d      = relu_en_i;
                    ch_cnt_d    = '0;
                    tile_cnt_d  = '0;
                    idx_d       = 5'd0;
                end else begin
                    ch_cnt_d = ch_cnt_q;
                end
            end
            S_CAPTURE: begin
                // First channel word loads, later ones add with natural wrap.
                for (int i = 0; i < N_ELEM; i++) begin
                    if (ch_cnt_q == '0) begin
                        acc_d[i] = ACC_WIDTH'($signed(fifo_dout_i[i*PSUM_WIDTH +: PSUM_WIDTH]));
                    end else begin
                        acc_d[i] = acc_q[i] + ACC_WIDTH'($signed(fifo_dout_i[i*PSUM_WIDTH +: PSUM_WIDTH]));
                    end
                end
                if (last_ch_s) begin
                    idx_d = 5'd0;
                end else begin
                    ch_cnt_d = ch_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_OUTPUT: begin
                if (accept_s) begin
                    if (last_idx_s) begin
                        idx_d = 5'd0;
                        if (!last_tile_s) begin
                            tile_cnt_d = tile_cnt_q + CNT_WIDTH'(1);
                            ch_cnt_d   = '0;
                        end else begin
                            tile_cnt_d = tile_cnt_q;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Outputs decoded from registered state; rd_en also gated by FIFO empty.
    always_comb begin
        fifo_rd_en_o = (state_q == S_FETCH) && !fifo_empty_i;
        act_valid_o  = (state_q == S_OUTPUT);
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_DONE);
        if (state_q == S_OUTPUT) begin
            act_o = requant(acc_q[idx_q], shift_q, relu_q);
        end else begin
            act_o = 8'd0;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: stimulus pushes expected activations,
// a negedge monitor pops and compares on every accepted output.
module tb_psum_collector;

    localparam int PW = 24;
    localparam int N  = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [7:0]      num_ch_i;
    logic [7:0]      num_tiles_i;
    logic [4:0]      shift_i;
    logic            relu_en_i;
    logic [N*PW-1:0] fifo_dout = '0;
    logic            fifo_empty_i;
    logic            fifo_rd_en_o;
    logic [7:0]      act_o;
    logic            act_valid_o;
    logic            act_ready_i = 1'b1;
    logic            busy_o;
    logic            done_o;

    always #5 clk = ~clk;

    psum_collector dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .num_ch_i     (num_ch_i),
        .num_tiles_i  (num_tiles_i),
        .shift_i      (shift_i),
        .relu_en_i    (relu_en_i),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .act_o        (act_o),
        .act_valid_o  (act_valid_o),
        .act_ready_i  (act_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // FIFO model
    logic [N*PW-1:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic empty_stall = 1'b0;
    assign fifo_empty_i = (wr_ptr == rd_ptr) || empty_stall;

    always @(posedge clk) begin
        if (fifo_rd_en_o && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en_o) rd_cnt <= rd_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
    end

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int acc_cnt = 0;
    int last_acc = -10;
    logic rand_mode = 1'b0;
    int wv [N];

    task automatic check(input string nm, input int act, input int want);
        total = total + 1;
        if (act != want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: scoreboard pop on accept, stall stability, rd/empty, done latency
    initial begin
        logic held_v;
        int   held_val;
        int   e;
        held_v = 1'b0;
        held_val = 0;
        forever begin
            @(negedge clk);
            if (fifo_rd_en_o) check("rd_while_empty", int'(fifo_empty_i), 0);
            if (act_valid_o && held_v) check("stall_hold", int'($signed(act_o)), held_val);
            held_v   = act_valid_o && !act_ready_i;
            held_val = int'($signed(act_o));
            if (act_valid_o && act_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", int'($signed(act_o)), 9999);
                end else begin
                    e = exp_q.pop_front();
                    check("act", int'($signed(act_o)), e);
                end
                last_acc = cyc;
                acc_cnt  = acc_cnt + 1;
            end
            if (done_o) check("done_latency", cyc, last_acc + 1);
        end
    end

    // Backpressure / empty randomizer
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                act_ready_i = ($urandom_range(0, 2) != 0);
                empty_stall = ($urandom_range(0, 2) == 0);
            end else begin
                act_ready_i = 1'b1;
                empty_stall = 1'b0;
            end
        end
    end

    task automatic push_word();
        logic [N*PW-1:0] w;
        for (int i = 0; i < N; i++) w[i*PW +: PW] = PW'(wv[i]);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start_job(input int nch, input int nt, input int sh, input logic relu);
        @(posedge clk);
        #1;
        num_ch_i    = 8'(nch);
        num_tiles_i = 8'(nt);
        shift_i     = 5'(sh);
        relu_en_i   = relu;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        num_ch_i    = 8'd7;
        num_tiles_i = 8'd9;
        shift_i     = 5'd3;
        relu_en_i   = ~relu;
    endtask

    task automatic wait_done(input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", int'(got), 1);
    endtask

    task automatic wait_accepts(input int base, input int cnt);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #1;
            if (acc_cnt - base == cnt) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_wait", int'(got), 1);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("idle_after", int'(busy_o), 0);
    endtask

    initial begin
        int r0;
        int d0;
        int a0;
        rst = 1'b1; start_i = 1'b0; num_ch_i = 8'd0; num_tiles_i = 8'd0;
        shift_i = 5'd0; relu_en_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", int'(fifo_rd_en_o), 0);
        check("rst_valid", int'(act_valid_o), 0);
        check("rst_act", int'(act_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        @(posedge clk); #1; rst = 1'b0;

        // 1: single channel, k-9; then start in the done cycle is ignored
        for (int k = 0; k < N; k++) begin wv[k] = k - 9; exp_q.push_back(k - 9); end
        push_word();
        r0 = rd_cnt; d0 = done_cnt;
        start_job(1, 1, 0, 1'b0);
        wait_done(200);
        start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", int'(busy_o), 0);
        check("t1_rd_strobes", rd_cnt - r0, 1);
        check("t1_done_pulses", done_cnt - d0, 1);
        settle();

        // 2: three channel words of 100, shift 2 -> 75
        for (int k = 0; k < N; k++) begin wv[k] = 100; exp_q.push_back(75); end
        repeat (3) push_word();
        r0 = rd_cnt;
        start_job(3, 1, 0 + 2, 1'b0);
        wait_done(300);
        check("t2_rd_strobes", rd_cnt - r0, 3);
        settle();

        // 3: requant edges
        for (int k = 0; k < N; k++) wv[k] = 0;
        wv[0] = 1000; wv[1] = -1000; wv[2] = -5;
        push_word();
        exp_q.push_back(127); exp_q.push_back(-128); exp_q.push_back(-5);
        for (int k = 3; k < N; k++) exp_q.push_back(0);
        start_job(1, 1, 0, 1'b0);
        wait_done(200);
        settle();
        push_word();
        exp_q.push_back(127); exp_q.push_back(-128); exp_q.push_back(-3);
        for (int k = 3; k < N; k++) exp_q.push_back(0);
        start_job(1, 1, 1, 1'b0);
        wait_done(200);
        settle();
        push_word();
        exp_q.push_back(127); exp_q.push_back(0); exp_q.push_back(0);
        for (int k = 3; k < N; k++) exp_q.push_back(0);
        start_job(1, 1, 0, 1'b1);
        wait_done(200);
        settle();

        // 4: random backpressure and empty, same vectors as test 1 over two words
        for (int k = 0; k < N; k++) begin wv[k] = k - 9; exp_q.push_back(2 * (k - 9)); end
        rand_mode = 1'b1;
        push_word();
        push_word();
        r0 = rd_cnt;
        start_job(2, 1, 0, 1'b0);
        wait_done(3000);
        rand_mode = 1'b0;
        check("t4_rd_strobes", rd_cnt - r0, 2);
        settle();

        // 5: reset at idx 7, then clean job
        for (int k = 0; k < N; k++) begin wv[k] = 50; exp_q.push_back(50); end
        push_word();
        a0 = acc_cnt;
        start_job(1, 1, 0, 1'b0);
        wait_accepts(a0, 7);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_valid", int'(act_valid_o), 0);
        check("rst_mid_busy", int'(busy_o), 0);
        check("rst_mid_rd_en", int'(fifo_rd_en_o), 0);
        for (int k = 0; k < N; k++) begin wv[k] = 1; exp_q.push_back(2); end
        push_word();
        push_word();
        start_job(2, 1, 0, 1'b0);
        wait_done(300);
        settle();

        // 6: two tiles with a stray start pulse mid-job
        for (int k = 0; k < N; k++) begin wv[k] = k; exp_q.push_back(k); end
        push_word();
        for (int k = 0; k < N; k++) begin wv[k] = -k; exp_q.push_back(-k); end
        push_word();
        a0 = acc_cnt; d0 = done_cnt;
        start_job(1, 2, 0, 1'b0);
        wait_accepts(a0, 20);
        num_tiles_i = 8'd5; num_ch_i = 8'd3; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        wait_done(400);
        repeat (3) @(negedge clk);
        check("t6_outputs", acc_cnt - a0, 36);
        check("t6_done_pulses", done_cnt - d0, 1);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
